// File: rtl/mem_access_unit.sv
// Load/store unit in front of a word-wide data RAM (combinational read, clocked write).
// Sub-word stores are done as read-modify-write; misaligned, out-of-range or illegal requests are rejected.
module mem_access_unit #(
    parameter int DEPTH    = 128,
    parameter int ADR_BITS = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [1:0]          req_size,
    input  logic                req_signed,
    input  logic [ADR_BITS-1:0] req_addr,
    input  logic [31:0]         req_wdata,
    output logic                resp_valid,
    output logic [31:0]         resp_rdata,
    output logic                resp_err,
    output logic                ram_wen,
    output logic [ADR_BITS-1:0] ram_adr,
    output logic [31:0]         ram_din,
    input  logic [31:0]         ram_dout
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WRITE,
        S_RESP
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    state_t r_state;
    state_t w_next_state;

    logic                r_we;
    logic [1:0]          r_size;
    logic                r_signed;
    logic [ADR_BITS-1:0] r_addr;
    logic [31:0]         r_wdata;
    logic [31:0]         r_merged;
    logic [31:0]         r_rdata;
    logic                r_err;

    logic                w_accept;
    logic                w_misaligned;
    logic                w_out_of_range;
    logic                w_req_err;
    logic [ADR_BITS-1:0] w_req_word;
    logic [ADR_BITS-1:0] w_word_idx;
    logic [7:0]          w_byte;
    logic [15:0]         w_half;
    logic [31:0]         w_load_data;
    logic [31:0]         w_merged;

    // Request checks operate on the live request fields so the verdict is ready at the accept edge.
    assign w_accept       = req_valid && (r_state == S_IDLE);
    assign w_req_word     = req_addr >> 2;
    assign w_out_of_range = (w_req_word >= ADR_BITS'(DEPTH));

    // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        w_misaligned = 1'b0;
        case (req_size)
            SZ_HALF: w_misaligned = req_addr[0];
            SZ_WORD: w_misaligned = |req_addr[1:0];
            default: w_misaligned = 1'b0;
        endcase
    end

    assign w_req_err  = (req_size == SZ_ILL) || w_misaligned || w_out_of_range;
    assign w_word_idx = r_addr >> 2;

    // Little-endian lane extraction and extension of the load result.
    always_comb begin
        w_byte = ram_dout[7:0];
        case (r_addr[1:0])
            2'd1:    w_byte = ram_dout[15:8];
            2'd2:    w_byte = ram_dout[23:16];
            2'd3:    w_byte = ram_dout[31:24];
            default: w_byte = ram_dout[7:0];
        endcase
        w_half = r_addr[1] ? ram_dout[31:16] : ram_dout[15:0];

        w_load_data = ram_dout;
        case (r_size)
            SZ_BYTE: w_load_data = {{24{r_signed && w_byte[7]}}, w_byte};
            SZ_HALF: w_load_data = {{16{r_signed && w_half[15]}}, w_half};
            default: w_load_data = ram_dout;
        endcase
    end

    // Store merge: the current RAM word with only the addressed lane replaced.
    always_comb begin
        w_merged = ram_dout;
        case (r_size)
            SZ_BYTE: w_merged[{r_addr[1:0], 3'b000} +: 8]  = r_wdata[7:0];
            SZ_HALF: w_merged[{r_addr[1], 4'b0000} +: 16]  = r_wdata[15:0];
            default: w_merged = r_wdata;
        endcase
    end

    // NOTE: state is held in flops updated with non-blocking assignments; reset is synchronous.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        req_ready    = 1'b0;
        resp_valid   = 1'b0;
        ram_wen      = 1'b0;
        ram_adr      = '0;
        ram_din      = '0;
        case (r_state)
            S_IDLE: begin
                req_ready = !rst;
                if (req_valid) begin
                    w_next_state = w_req_err ? S_RESP : S_ACCESS;
                end
            end
            S_ACCESS: begin
                ram_adr      = w_word_idx;
                w_next_state = r_we ? S_WRITE : S_RESP;
            end
            S_WRITE: begin
                // Gated by rst so a reset edge can never commit a half-finished store.
                ram_wen      = !rst;
                ram_adr      = w_word_idx;
                ram_din      = r_merged;
                w_next_state = S_RESP;
            end
            S_RESP: begin
                resp_valid   = 1'b1;
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_we     <= 1'b0;
            r_size   <= 2'b00;
            r_signed <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_merged <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_we     <= req_we;
                r_size   <= req_size;
                r_signed <= req_signed;
                r_addr   <= req_addr;
                r_wdata  <= req_wdata;
                if (w_req_err) begin
                    r_err   <= 1'b1;
                    r_rdata <= '0;
                end
            end
            // Response registers change only when this transaction's result is known.
            if (r_state == S_ACCESS) begin
                if (r_we) begin
                    r_merged <= w_merged;
                end else begin
                    r_rdata <= w_load_data;
                    r_err   <= 1'b0;
                end
            end
            if (r_state == S_WRITE) begin
                r_rdata <= '0;
                r_err   <= 1'b0;
            end
        end
    end

    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, reset and back-to-back sequences,
// then random traffic checked against a byte-addressed memory model.
module tb_mem_access_unit;

    localparam int DEPTH    = 128;
    localparam int ADR_BITS = 32;
    localparam int IDXW     = $clog2(DEPTH);

    localparam logic [1:0] B = 2'b00;
    localparam logic [1:0] H = 2'b01;
    localparam logic [1:0] W = 2'b10;
    localparam logic [1:0] X = 2'b11;

    logic                clk = 1'b0;
    logic                rst;
    logic                req_valid;
    logic                req_ready;
    logic                req_we;
    logic [1:0]          req_size;
    logic                req_signed;
    logic [ADR_BITS-1:0] req_addr;
    logic [31:0]         req_wdata;
    logic                resp_valid;
    logic [31:0]         resp_rdata;
    logic                resp_err;
    logic                ram_wen;
    logic [ADR_BITS-1:0] ram_adr;
    logic [31:0]         ram_din;
    logic [31:0]         ram_dout;

    logic [31:0] mem [DEPTH];
    logic [7:0]  ref_bytes [4*DEPTH];
    int          wen_total = 0;
    int          n_checks  = 0;
    int          n_fail    = 0;

    typedef struct {
        logic        pre_en;
        int          pre_idx;
        logic [31:0] pre_val;
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_wen;
        int          chk_idx;
        logic [31:0] chk_val;
    } vec_t;

    vec_t vecs [19];

    always #5 clk = ~clk;

    mem_access_unit #(.DEPTH(DEPTH), .ADR_BITS(ADR_BITS)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .ram_wen    (ram_wen),
        .ram_adr    (ram_adr),
        .ram_din    (ram_din),
        .ram_dout   (ram_dout)
    );

    always_comb begin
        ram_dout = 32'h0;
        if (ram_adr < ADR_BITS'(DEPTH)) ram_dout = mem[ram_adr[IDXW-1:0]];
    end

    always @(posedge clk) begin
        if (ram_wen) begin
            wen_total = wen_total + 1;
            if (ram_adr < ADR_BITS'(DEPTH)) mem[ram_adr[IDXW-1:0]] = ram_din;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: memory as a flat little-endian byte array.
    function automatic void model(input logic we, input logic [1:0] size, input logic sgn,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  output logic [31:0] rdata, output logic err);
        int          nb;
        logic [31:0] v;
        rdata = 32'h0;
        err   = 1'b0;
        nb    = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        if (size == 2'b11 || (addr % nb) != 0 || (addr / 4) >= DEPTH) begin
            err = 1'b1;
            return;
        end
        if (we) begin
            for (int i = 0; i < nb; i++) ref_bytes[int'(addr) + i] = wdata[8*i +: 8];
        end else begin
            v = 32'h0;
            for (int i = 0; i < nb; i++) v = v | (32'(ref_bytes[int'(addr) + i]) << (8*i));
            rdata = v;
            if (sgn && nb < 4 && v[8*nb-1]) rdata = v | (32'hFFFF_FFFF << (8*nb));
        end
    endfunction

    task automatic run_req(input logic we, input logic [1:0] size, input logic sgn,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output logic [31:0] rdata, output logic err, output int lat,
                           output int n_wen, output int wen_cyc, output logic busy_ready,
                           output logic post_valid, output logic post_ready);
        int guard;
        rdata = 32'h0; err = 1'b0; lat = -1; n_wen = 0; wen_cyc = -1;
        busy_ready = 1'b0; post_valid = 1'b0; post_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
        req_addr = addr; req_wdata = wdata;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_we     = 1'($urandom);
        req_size   = 2'($urandom);
        req_signed = 1'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (ram_wen) begin
                n_wen++;
                if (wen_cyc < 0) wen_cyc = c;
            end
            if (resp_valid) begin
                lat   = c;
                rdata = resp_rdata;
                err   = resp_err;
                break;
            end
            if (req_ready) busy_ready = 1'b1;
        end
        @(negedge clk);
        post_valid = resp_valid;
        post_ready = req_ready;
        if (ram_wen) n_wen++;
    endtask

    initial begin
        logic [31:0] g_rdata, e_rdata, addr, wdata;
        logic        g_err, e_err, busy_ready, post_valid, post_ready, we, sgn, any_valid;
        logic [1:0]  size;
        logic [5:0]  b2b_valid, b2b_ready;
        logic [31:0] b2b_rdata [6];
        int          lat, n_wen, wen_cyc, wen_before, mism, r;

        for (int w = 0; w < DEPTH; w++) mem[w] = $urandom;

        vecs[0]  = '{1'b1, 3,   32'h11223344, 1'b1, W, 1'b0, 32'h0000000C, 32'hAABBCCDD, 32'h00000000, 1'b0, 3, 1, 3,   32'hAABBCCDD};
        vecs[1]  = '{1'b1, 3,   32'h80FF7F01, 1'b0, B, 1'b1, 32'h0000000D, 32'h00000000, 32'h0000007F, 1'b0, 2, 0, 3,   32'h80FF7F01};
        vecs[2]  = '{1'b0, 0,   32'h00000000, 1'b0, B, 1'b1, 32'h0000000F, 32'h00000000, 32'hFFFFFF80, 1'b0, 2, 0, 3,   32'h80FF7F01};
        vecs[3]  = '{1'b0, 0,   32'h00000000, 1'b0, B, 1'b0, 32'h0000000F, 32'h00000000, 32'h00000080, 1'b0, 2, 0, 3,   32'h80FF7F01};
        vecs[4]  = '{1'b0, 0,   32'h00000000, 1'b1, H, 1'b1, 32'h0000000E, 32'hDEAD1234, 32'h00000000, 1'b0, 3, 1, 3,   32'h12347F01};
        vecs[5]  = '{1'b0, 0,   32'h00000000, 1'b0, H, 1'b1, 32'h0000000C, 32'h00000000, 32'h00007F01, 1'b0, 2, 0, 3,   32'h12347F01};
        vecs[6]  = '{1'b0, 0,   32'h00000000, 1'b0, H, 1'b1, 32'h0000000E, 32'h00000000, 32'h00001234, 1'b0, 2, 0, 3,   32'h12347F01};
        vecs[7]  = '{1'b0, 0,   32'h00000000, 1'b0, W, 1'b0, 32'h0000000D, 32'h00000000, 32'h00000000, 1'b1, 1, 0, 3,   32'h12347F01};
        vecs[8]  = '{1'b1, 2,   32'h5A5A5A5A, 1'b1, H, 1'b0, 32'h0000000B, 32'h0000FFFF, 32'h00000000, 1'b1, 1, 0, 2,   32'h5A5A5A5A};
        vecs[9]  = '{1'b0, 0,   32'h00000000, 1'b1, X, 1'b0, 32'h0000000C, 32'h99999999, 32'h00000000, 1'b1, 1, 0, 3,   32'h12347F01};
        vecs[10] = '{1'b1, 0,   32'hC3C3C3C3, 1'b1, B, 1'b0, 32'h00000200, 32'h000000EE, 32'h00000000, 1'b1, 1, 0, 0,   32'hC3C3C3C3};
        vecs[11] = '{1'b1, 127, 32'h00112233, 1'b1, B, 1'b0, 32'h000001FF, 32'h123456A5, 32'h00000000, 1'b0, 3, 1, 127, 32'hA5112233};
        vecs[12] = '{1'b0, 0,   32'h00000000, 1'b0, B, 1'b1, 32'h000001FF, 32'h00000000, 32'hFFFFFFA5, 1'b0, 2, 0, 127, 32'hA5112233};
        vecs[13] = '{1'b0, 0,   32'h00000000, 1'b0, H, 1'b1, 32'h000001FE, 32'h00000000, 32'hFFFFA511, 1'b0, 2, 0, 127, 32'hA5112233};
        vecs[14] = '{1'b0, 0,   32'h00000000, 1'b0, W, 1'b1, 32'h000001FC, 32'h00000000, 32'hA5112233, 1'b0, 2, 0, 127, 32'hA5112233};
        vecs[15] = '{1'b0, 0,   32'h00000000, 1'b1, H, 1'b0, 32'h0000000C, 32'h0000BEEF, 32'h00000000, 1'b0, 3, 1, 3,   32'h1234BEEF};
        vecs[16] = '{1'b0, 0,   32'h00000000, 1'b0, B, 1'b0, 32'h0000000D, 32'h00000000, 32'h000000BE, 1'b0, 2, 0, 3,   32'h1234BEEF};
        vecs[17] = '{1'b0, 0,   32'h00000000, 1'b0, B, 1'b1, 32'h0000000C, 32'h00000000, 32'hFFFFFFEF, 1'b0, 2, 0, 3,   32'h1234BEEF};
        vecs[18] = '{1'b0, 0,   32'h00000000, 1'b0, W, 1'b0, 32'h10000000, 32'h00000000, 32'h00000000, 1'b1, 1, 0, 3,   32'h1234BEEF};

        // Reset
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_ready_during", 32'(req_ready), 32'h0);
        check("rst_wen_during", 32'(ram_wen), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_ready_after", 32'(req_ready), 32'h1);
        check("rst_resp_valid", 32'(resp_valid), 32'h0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_resp_err", 32'(resp_err), 32'h0);
        check("rst_ram_adr", ram_adr, 32'h0);
        check("rst_ram_din", ram_din, 32'h0);

        // Directed vectors
        for (int i = 0; i < 19; i++) begin
            if (vecs[i].pre_en) mem[vecs[i].pre_idx] = vecs[i].pre_val;
            wen_before = wen_total;
            run_req(vecs[i].we, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata,
                    g_rdata, g_err, lat, n_wen, wen_cyc, busy_ready, post_valid, post_ready);
            check($sformatf("vec%0d_rdata", i), g_rdata, vecs[i].exp_rdata);
            check($sformatf("vec%0d_err", i), 32'(g_err), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            check($sformatf("vec%0d_wen_count", i), 32'(wen_total - wen_before), 32'(vecs[i].exp_wen));
            check($sformatf("vec%0d_wen_cycle", i), 32'(wen_cyc), (vecs[i].exp_wen != 0) ? 32'd2 : 32'hFFFF_FFFF);
            check($sformatf("vec%0d_ready_busy", i), 32'(busy_ready), 32'h0);
            check($sformatf("vec%0d_resp_one_cycle", i), 32'(post_valid), 32'h0);
            check($sformatf("vec%0d_ready_after", i), 32'(post_ready), 32'h1);
            check($sformatf("vec%0d_mem", i), mem[vecs[i].chk_idx], vecs[i].chk_val);
        end

        // Reset asserted during the WRITE cycle of a word store
        @(negedge clk);
        mem[5] = 32'h01020304;
        wen_before = wen_total;
        req_valid = 1'b1; req_we = 1'b1; req_size = W; req_signed = 1'b0;
        req_addr = 32'h14; req_wdata = 32'hCAFEF00D;
        check("rstw_ready_pre", 32'(req_ready), 32'h1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1;
        check("rstw_wen_in_write", 32'(ram_wen), 32'h1);
        check("rstw_adr_in_write", ram_adr, 32'h5);
        rst = 1'b1;
        #1;
        check("rstw_wen_gated", 32'(ram_wen), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rstw_ready_after", 32'(req_ready), 32'h1);
        any_valid = resp_valid;
        repeat (3) begin
            @(negedge clk);
            any_valid = any_valid | resp_valid;
        end
        check("rstw_no_response", 32'(any_valid), 32'h0);
        check("rstw_mem_kept", mem[5], 32'h01020304);
        check("rstw_no_write", 32'(wen_total - wen_before), 32'h0);

        // Back-to-back loads with req_valid held high
        @(negedge clk);
        mem[10] = 32'h13579BDF;
        mem[11] = 32'h2468ACE0;
        req_valid = 1'b1; req_we = 1'b0; req_size = W; req_signed = 1'b0; req_addr = 32'h28;
        @(posedge clk);
        #1 req_size = H; req_addr = 32'h2E;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            b2b_valid[c] = resp_valid;
            b2b_ready[c] = req_ready;
            b2b_rdata[c] = resp_rdata;
            if (c == 4) req_valid = 1'b0;
        end
        check("b2b_valid_pattern", 32'(b2b_valid), 32'(6'b010010));
        check("b2b_ready_pattern", 32'(b2b_ready), 32'(6'b100100));
        check("b2b_first_rdata", b2b_rdata[1], 32'h13579BDF);
        check("b2b_second_rdata", b2b_rdata[4], 32'h00002468);

        // Random traffic against the byte-array model
        for (int i = 0; i < 4*DEPTH; i++) ref_bytes[i] = mem[i/4][8*(i%4) +: 8];
        for (int n = 0; n < 250; n++) begin
            we   = 1'($urandom);
            sgn  = 1'($urandom);
            size = ($urandom_range(0, 9) == 0) ? X : 2'($urandom_range(0, 2));
            r    = $urandom_range(0, 19);
            if (r == 0)      addr = $urandom;
            else if (r == 1) addr = 32'(4*DEPTH + $urandom_range(0, 15));
            else if (r < 10) addr = 32'($urandom_range(0, 63));
            else             addr = 32'($urandom_range(0, 4*DEPTH-1));
            wdata = $urandom;
            model(we, size, sgn, addr, wdata, e_rdata, e_err);
            wen_before = wen_total;
            run_req(we, size, sgn, addr, wdata,
                    g_rdata, g_err, lat, n_wen, wen_cyc, busy_ready, post_valid, post_ready);
            check($sformatf("rand%0d_rdata a=%08h sz=%0d we=%0d", n, addr, size, we), g_rdata, e_rdata);
            check($sformatf("rand%0d_err", n), 32'(g_err), 32'(e_err));
            check($sformatf("rand%0d_latency", n), 32'(lat), e_err ? 32'd1 : (we ? 32'd3 : 32'd2));
            check($sformatf("rand%0d_wen_count", n), 32'(wen_total - wen_before), 32'(!e_err && we));
        end
        mism = 0;
        for (int w = 0; w < DEPTH; w++) begin
            if (mem[w] !== {ref_bytes[4*w+3], ref_bytes[4*w+2], ref_bytes[4*w+1], ref_bytes[4*w]})
                mism++;
        end
        check("rand_mem_words_differing", 32'(mism), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store unit sitting directly upstream of the word-wide data RAM.
- Accepts one memory request at a time from the core over a valid/ready handshake, with byte, halfword or word size and signed or unsigned loads.
- Translates the byte address into a word index. Sub-word stores use read-modify-write, since the RAM has a combinational read and a clocked, word-only write.
- Returns the aligned and extended load data, or an error flag for misaligned, out-of-range or illegal requests.

Parameters:
- DEPTH, 128: number of 32-bit words in the attached RAM. Word index >= DEPTH is out of range.
- ADR_BITS, 32: width of the byte address and of ram_adr.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_signed  in  1  sign-extend loads (ignored for word loads and for stores)
- req_addr  in  ADR_BITS  byte address
- req_wdata  in  32  store data, taken from the low bits
- resp_valid  out  1  one-cycle response strobe
- resp_rdata  out  32  load result (0 for stores and errors)
- resp_err  out  1  request rejected, no RAM write occurred
- ram_wen  out  1  RAM write enable
- ram_adr  out  ADR_BITS  word index = latched req_addr >> 2
- ram_din  out  32  word to write
- ram_dout  in  32  combinational RAM read data at ram_adr

Behaviour:
- Clock and reset: single clock, clk. Reset is synchronous, active-high, on rst.
- FSM states: IDLE, ACCESS, WRITE, RESP.
- Reset values: state IDLE; resp_valid, resp_err and resp_rdata all 0; latched request registers 0.
- ram_wen = (state==WRITE) && !rst, so no write can ever occur on a reset edge.
- req_ready = (state==IDLE) && !rst. A transfer happens when req_valid && req_ready at a rising edge; all req_* fields are latched on that edge.
- Error check (in IDLE, on the accepted request):
  - size==11; or
  - half with addr[0]!=0; or
  - word with addr[1:0]!=0; or
  - (addr>>2) >= DEPTH.
  - On error: go to RESP with resp_err=1 and resp_rdata=0. The RAM is never written.
- IDLE -> ACCESS on a legal accepted request.
- ACCESS:
  - ram_adr = latched word index.
  - Load: extract the lane from ram_dout, zero- or sign-extend to 32 bits, register into resp_rdata, go to RESP.
  - Store: register the merged word, go to WRITE.
- Lane selection (little-endian):
  - byte lane k = addr[1:0] occupies bits [8k+7:8k];
  - half at addr[1]=0 occupies [15:0], at addr[1]=1 occupies [31:16].
- Merge: ram_dout with the selected lane replaced by req_wdata[7:0] (byte) or [15:0] (half). A word store replaces all 32 bits; the read is still performed, so timing stays uniform.
- WRITE: ram_wen=1, ram_adr = word index, ram_din = merged word; go to RESP.
- RESP: resp_valid=1 for exactly one cycle, resp_rdata and resp_err held; go to IDLE. resp_valid is 0 in all other states.
- resp_rdata and resp_err keep their values until the next response.
- Latency (accept edge = cycle 0):
  - error response valid in cycle 1;
  - load response in cycle 2;
  - store response in cycle 3; the RAM write commits at the end of cycle 2.
- Throughput: the next request is accepted in the cycle after RESP. There is no back-to-back overlap.
- RAM-side outputs in IDLE and RESP: ram_adr, ram_din and ram_wen all 0.
- Reset mid-operation: any state returns to IDLE and the pending request is dropped with no response. If reset occurs in WRITE, the write is suppressed.
- req_valid deasserting while the unit is busy has no effect, because requests are latched at acceptance.

Test Plan:
- Reset: RAM[3]=0x11223344. Store word 0xAABBCCDD to addr 0x0C -> req_ready low for cycles 1-3, RAM write at the end of cycle 2, resp_valid in cycle 3 with err=0 and rdata=0; RAM[3]=0xAABBCCDD.
- Signed byte load: RAM[3]=0x80FF7F01, addr 0x0D, size 00, req_signed=1 -> cycle 2 rdata=0x0000007F. Same load at addr 0x0F -> 0xFFFFFF80. Unsigned load at addr 0x0F -> 0x00000080.
- Half store: RAM[3]=0x80FF7F01, store half 0x1234 at addr 0x0E -> RAM[3]=0x12347F01. Then a signed half load at 0x0C -> 0x00007F01, and a signed half load at 0x0E -> 0x00001234.
- Errors, each giving resp_err=1 in cycle 1, ram_wen never high and the RAM unchanged:
  - word load at 0x0D;
  - half store at 0x0B;
  - size 11;
  - byte store at addr 4*DEPTH (0x200).
- Reset mid-store: assert rst during the WRITE cycle -> no RAM write, no resp_valid, and req_ready=1 in the first cycle after rst deasserts.
- Back-to-back: req_valid held high with two loads -> the second is accepted only in the cycle after the first RESP; both responses are correct and in order.
